pc_sequencer: RTL

PC_SEQUENCER -- requirements
Module: pc_sequencer

---
 rtl/riscv_pkg.sv | 22 ++
 rtl/next_pc_mux.sv | 83 ++++++++
 rtl/program_counter.sv | 26 ++
 rtl/pc_sequencer.sv | 116 +++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared definitions for the PC sequencing slice: sequencer state encoding,
// PC increment, default vectors and an alignment helper.
package riscv_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2,
        ST_TRAP = 2'd3
    } seq_state_e;

    localparam logic [31:0] PC_INC               = 32'd4;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_TRAP_VECTOR  = 32'h0000_0100;
    localparam int unsigned DEFAULT_BOOT_CYCLES  = 4;

    // Instruction addresses must be word aligned.
    function automatic logic is_misaligned(input logic [31:0] addr);
        return addr[1:0] != 2'b00;
    endfunction

endpackage

// File: rtl/next_pc_mux.sv
// Combinational next-PC selection. Also reports which redirect was chosen
// in RUN so the sequencer FSM can take its state transition.
module next_pc_mux
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR
) (
    input  logic        reset_ni,
    input  seq_state_e  state_i,
    input  logic [31:0] pc_cur_i,
    input  logic        stall_i,
    input  logic        branch_taken_i,
    input  logic [31:0] branch_target_i,
    input  logic        jalr_en_i,
    input  logic [31:0] jalr_target_i,
    input  logic        trap_req_i,
    input  logic        halt_req_i,
    output logic [31:0] pc_next_o,
    output logic        fetch_en_o,
    output logic        trap_o,
    output logic        halt_o,
    output logic        misalign_o
);

    logic [31:0] jalr_addr;

    assign jalr_addr = jalr_target_i & ~32'd1;

    // Priority mux: trap > halt > jalr > branch > stall > sequential.
    always_comb begin
        pc_next_o  = RESET_VECTOR;
        fetch_en_o = 1'b0;
        trap_o     = 1'b0;
        halt_o     = 1'b0;
        misalign_o = 1'b0;
        if (reset_ni) begin
            unique case (state_i)
                ST_BOOT: begin
                    pc_next_o = RESET_VECTOR;
                end
                ST_RUN: begin
                    fetch_en_o = 1'b1;
                    if (trap_req_i) begin
                        pc_next_o = TRAP_VECTOR;
                        trap_o    = 1'b1;
                    end else if (halt_req_i) begin
                        pc_next_o = pc_cur_i;
                        halt_o    = 1'b1;
                    end else if (jalr_en_i) begin
                        if (is_misaligned(jalr_addr)) begin
                            pc_next_o  = TRAP_VECTOR;
                            misalign_o = 1'b1;
                        end else begin
                            pc_next_o = jalr_addr;
                        end
                    end else if (branch_taken_i) begin
                        if (is_misaligned(branch_target_i)) begin
                            pc_next_o  = TRAP_VECTOR;
                            misalign_o = 1'b1;
                        end else begin
                            pc_next_o = branch_target_i;
                        end
                    end else if (stall_i) begin
                        pc_next_o = pc_cur_i;
                    end else begin
                        pc_next_o = pc_cur_i + PC_INC;
                    end
                end
                ST_HALT: begin
                    pc_next_o = pc_cur_i;
                end
                ST_TRAP: begin
                    pc_next_o = TRAP_VECTOR;
                end
                default: begin
                    pc_next_o = RESET_VECTOR;
                end
            endcase
        end
    end

endmodule

// File: rtl/program_counter.sv
// Program counter register: loads pc_in every cycle.
module program_counter
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_in,
    output logic [31:0] pc_out
);

    logic [31:0] pc_q;

    // PC register with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset) begin
            pc_q <= RESET_VECTOR;
        end else begin
            pc_q <= pc_in;
        end
    end

    assign pc_out = pc_q;

endmodule

// File: rtl/pc_sequencer.sv
// PC sequencer: BOOT/RUN/HALT/TRAP control FSM with boot counter, exception
// PC capture and misalignment pulse. Next-PC selection lives in next_pc_mux.
module pc_sequencer
    import riscv_pkg::*;
#(
    parameter logic [31:0] RESET_VECTOR = DEFAULT_RESET_VECTOR,
    parameter logic [31:0] TRAP_VECTOR  = DEFAULT_TRAP_VECTOR,
    parameter int unsigned BOOT_CYCLES  = DEFAULT_BOOT_CYCLES
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] pc_cur,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    input  logic        jalr_en,
    input  logic [31:0] jalr_target,
    input  logic        trap_req,
    input  logic        halt_req,
    input  logic        resume,
    output logic [31:0] pc_next,
    output logic        fetch_en,
    output logic [1:0]  state,
    output logic [31:0] epc,
    output logic        misalign_err
);

    localparam logic [3:0] BOOT_INIT = 4'(BOOT_CYCLES - 1);

    seq_state_e  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] epc_q, epc_d;
    logic        mis_q, mis_d;

    logic        take_trap;
    logic        take_halt;
    logic        take_mis;

    next_pc_mux #(
        .RESET_VECTOR (RESET_VECTOR),
        .TRAP_VECTOR  (TRAP_VECTOR)
    ) u_mux (
        .reset_ni        (reset),
        .state_i         (state_q),
        .pc_cur_i        (pc_cur),
        .stall_i         (stall),
        .branch_taken_i  (branch_taken),
        .branch_target_i (branch_target),
        .jalr_en_i       (jalr_en),
        .jalr_target_i   (jalr_target),
        .trap_req_i      (trap_req),
        .halt_req_i      (halt_req),
        .pc_next_o       (pc_next),
        .fetch_en_o      (fetch_en),
        .trap_o          (take_trap),
        .halt_o          (take_halt),
        .misalign_o      (take_mis)
    );

    // Next-state logic: boot countdown, trap/halt entry, single-cycle TRAP.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        epc_d   = epc_q;
        mis_d   = 1'b0;
        unique case (state_q)
            ST_BOOT: begin
                if (cnt_q == '0) begin
                    state_d = ST_RUN;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            ST_RUN: begin
                if (take_trap || take_mis) begin
                    state_d = ST_TRAP;
                    epc_d   = pc_cur;
                    mis_d   = take_mis;
                end else if (take_halt) begin
                    state_d = ST_HALT;
                end
            end
            ST_HALT: begin
                if (resume) begin
                    state_d = ST_RUN;
                end
            end
            ST_TRAP: begin
                state_d = ST_RUN;
            end
            default: begin
                state_d = ST_BOOT;
            end
        endcase
    end

    // State, counter, epc and misalign pulse registers.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q <= ST_BOOT;
            cnt_q   <= BOOT_INIT;
            epc_q   <= '0;
            mis_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            epc_q   <= epc_d;
            mis_q   <= mis_d;
        end
    end

    assign state        = state_q;
    assign epc          = epc_q;
    assign misalign_err = mis_q;

endmodule
